// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_pkg
// Description : Shared LC3 types and constants for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_pkg;

    typedef logic [15:0] lc3_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    localparam lc3_word_t LC3_DEFAULT_RESET_PC = 16'h3000;

endpackage : lc3_pkg
`default_nettype wire

// File: rtl/lc3_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_pc_reg
// Description : LC3 program counter with async reset, branch load and
//               increment; also presents pc+1 (modulo 2^16).
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_pc_reg
    import lc3_pkg::*;
#(
    parameter lc3_word_t RESET_PC = LC3_DEFAULT_RESET_PC
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_update,
    input  logic      i_load,
    input  lc3_word_t i_taddr,
    output lc3_word_t o_pc,
    output lc3_word_t o_npc
);

    lc3_word_t r_pc;
    lc3_word_t w_npc;

    // 16-bit add wraps naturally, so FFFF+1 yields 0000
    assign w_npc = r_pc + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_update) begin
            r_pc <= i_load ? i_taddr : w_npc;
        end
    end

    assign o_pc  = r_pc;
    assign o_npc = w_npc;

endmodule : lc3_pc_reg
`default_nettype wire

// File: rtl/lc3_fetch.sv
`default_nettype none
// ============================================================================
// Module      : lc3_fetch
// Description : LC3 fetch stage: PC ownership, instruction-memory read strobe
//               and decode qualification with branch bubble insertion.
//               Optional macro LC3_FETCH_COUNT_EN adds a 32-bit fetch_count.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_fetch
    import lc3_pkg::*;
#(
    parameter lc3_word_t   RESET_PC     = LC3_DEFAULT_RESET_PC,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_updatePC,
    input  logic        enable_fetch,
    input  logic        br_taken,
    input  logic [15:0] taddr,
    output logic [15:0] pc,
    output logic [15:0] npc_out,
    output logic        instrmem_rd,
    output logic        enable_decode
`ifdef LC3_FETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam logic [2:0] c_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [2:0]   r_cnt;
    logic [2:0]   w_cnt_nxt;
    logic         r_enable_decode;
    logic         w_enable_decode_nxt;
    logic         w_active;
    logic         w_taken;
    logic         w_update;
    logic         w_load;

    assign w_active = (r_state != IDLE);
    assign w_taken  = br_taken & enable_updatePC;
    assign w_update = w_active & enable_updatePC;
    assign w_load   = w_update & br_taken;

    lc3_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .i_update (w_update),
        .i_load   (w_load),
        .i_taddr  (taddr),
        .o_pc     (pc),
        .o_npc    (npc_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_cnt           <= 3'd0;
            r_enable_decode <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_enable_decode <= w_enable_decode_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_cnt_nxt           = r_cnt;
        w_enable_decode_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                // the word arriving after a redirect is wrong-path, never decoded
                w_enable_decode_nxt = enable_fetch & ~w_taken;
                if (w_taken) begin
                    w_state_nxt = FLUSH;
                    w_cnt_nxt   = c_FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (w_taken) begin
                    w_cnt_nxt = c_FLUSH_LOAD;
                end else if (r_cnt == 3'd0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    assign instrmem_rd   = w_active & enable_fetch;
    assign enable_decode = r_enable_decode;

`ifdef LC3_FETCH_COUNT_EN
    logic [31:0] r_fetch_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_count <= 32'd0;
        end else if (r_enable_decode) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

endmodule : lc3_fetch
`default_nettype wire
